// File: rtl/gpio_input_filter_if.sv
// gpio_input_filter_if: bundles the pad-side inputs, the static filter
// configuration and the conditioned outputs of gpio_input_filter.
// master = the side that drives pads/configuration (peripheral or bench),
// slave  = the filter itself.
interface gpio_input_filter_if #(
    parameter int IO_COUNT       = 16,
    parameter int DEBOUNCE_WIDTH = 4
);
    logic [IO_COUNT-1:0]       pad_input;
    logic [IO_COUNT-1:0]       filterEnable;
    logic [15:0]               samplePeriod;
    logic [DEBOUNCE_WIDTH-1:0] debounceCount;
    logic [IO_COUNT-1:0]       gpio_filtered;
    logic [IO_COUNT-1:0]       gpio_risingEdge;
    logic [IO_COUNT-1:0]       gpio_fallingEdge;

    modport master (
        output pad_input,
        output filterEnable,
        output samplePeriod,
        output debounceCount,
        input  gpio_filtered,
        input  gpio_risingEdge,
        input  gpio_fallingEdge
    );

    modport slave (
        input  pad_input,
        input  filterEnable,
        input  samplePeriod,
        input  debounceCount,
        output gpio_filtered,
        output gpio_risingEdge,
        output gpio_fallingEdge
    );
endinterface

// File: rtl/gpio_input_filter.sv
// gpio_input_filter: two-flop synchroniser on every pad, shared sample-tick
// prescaler and per-pin debounce counter, producing a glitch-free
// gpio_filtered bus plus optional one-cycle edge pulses.
// Build option: define GPIO_FILTER_EDGE_EN to build the edge-detect register
// and pulse logic; otherwise gpio_risingEdge/gpio_fallingEdge are tied to 0.
// Reset is synchronous and active-high.
module gpio_input_filter #(
    parameter int IO_COUNT       = 16,
    parameter int DEBOUNCE_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    gpio_input_filter_if.slave  bus
);

    logic [IO_COUNT-1:0]       sync1;
    logic [IO_COUNT-1:0]       sync2;
    logic [IO_COUNT-1:0]       filtered;
    logic [15:0]               tickCounter;
    logic                      sampleTick;
    logic [DEBOUNCE_WIDTH-1:0] stable [IO_COUNT];

    // Two-flop synchroniser; never bypassed, even for unfiltered pins.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.pad_input;
            sync2 <= sync1;
        end
    end

    // '>=' rather than '==' so a samplePeriod lowered below the running
    // count ticks on the next cycle instead of waiting for a 16-bit wrap.
    assign sampleTick = (tickCounter >= bus.samplePeriod);

    // Shared prescaler: reload to 0 on every tick, otherwise count up.
    always_ff @(posedge clk) begin
        if (rst) begin
            tickCounter <= '0;
        end else if (sampleTick) begin
            tickCounter <= '0;
        end else begin
            tickCounter <= tickCounter + 16'd1;
        end
    end

    // Per-pin bypass or debounce; stable counts consecutive mismatching
    // ticks and is capped at debounceCount, so it can never wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            filtered <= '0;
            // NOTE: the stability counters are a small register array, not a RAM, and are reset so a partial count never survives reset.
            for (int i = 0; i < IO_COUNT; i++) begin
                stable[i] <= '0;
            end
        end else begin
            for (int i = 0; i < IO_COUNT; i++) begin
                if (!bus.filterEnable[i]) begin
                    filtered[i] <= sync2[i];
                    stable[i]   <= '0;
                end else if (sampleTick) begin
                    if (sync2[i] == filtered[i]) begin
                        stable[i] <= '0;
                    end else if (stable[i] >= bus.debounceCount) begin
                        filtered[i] <= sync2[i];
                        stable[i]   <= '0;
                    end else begin
                        stable[i] <= stable[i] + DEBOUNCE_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign bus.gpio_filtered = filtered;

`ifdef GPIO_FILTER_EDGE_EN
    logic [IO_COUNT-1:0] gpio_filtered_d;

    // One-cycle delayed copy of the filtered bus; cleared by reset together
    // with filtered, so reset never produces an edge pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            gpio_filtered_d <= '0;
        end else begin
            gpio_filtered_d <= filtered;
        end
    end

    assign bus.gpio_risingEdge  = filtered & ~gpio_filtered_d;
    assign bus.gpio_fallingEdge = ~filtered & gpio_filtered_d;
`else
    assign bus.gpio_risingEdge  = '0;
    assign bus.gpio_fallingEdge = '0;
`endif

endmodule

// File: tb/tb_gpio_input_filter.sv
// tb_gpio_input_filter: directed test-plan scenarios plus randomized
// stimulus. A behavioural model pushes the expected outputs of every clock
// edge into a queue; an independent monitor pops and compares on the
// falling edge. Edge expectations follow the GPIO_FILTER_EDGE_EN build.
module tb_gpio_input_filter;

    localparam int IO_COUNT       = 16;
    localparam int DEBOUNCE_WIDTH = 4;

`ifdef GPIO_FILTER_EDGE_EN
    localparam logic [15:0] edgeMask = 16'hFFFF;
`else
    localparam logic [15:0] edgeMask = 16'h0000;
`endif

    typedef struct packed {
        logic [15:0] filtered;
        logic [15:0] rising;
        logic [15:0] falling;
    } expected_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    expected_t expQ[$];
    expected_t monExp;

    // Reference model state
    logic [15:0] padDelay[$];
    int          cyclesSinceTick;
    int          mismatchRun [IO_COUNT];
    logic [15:0] mFilt;

    gpio_input_filter_if #(.IO_COUNT(IO_COUNT), .DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)) bus ();

    gpio_input_filter #(.IO_COUNT(IO_COUNT), .DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs after one clock edge, from the behavioural rules:
    // the filter sees the pad value from two edges earlier; a tick happens
    // once the cycles since the last tick reach samplePeriod; a debounced
    // pin follows after more than debounceCount consecutive mismatching ticks.
    task automatic modelStep();
        expected_t   e;
        logic [15:0] syncOut;
        logic [15:0] prevFilt;
        logic        tick;
        e = '0;
        if (rst) begin
            padDelay        = '{16'h0000, 16'h0000};
            cyclesSinceTick = 0;
            for (int i = 0; i < IO_COUNT; i++) mismatchRun[i] = 0;
            mFilt = '0;
        end else begin
            syncOut = padDelay.pop_front();
            padDelay.push_back(bus.pad_input);
            tick = (cyclesSinceTick >= int'(bus.samplePeriod));
            cyclesSinceTick = tick ? 0 : cyclesSinceTick + 1;
            prevFilt = mFilt;
            for (int i = 0; i < IO_COUNT; i++) begin
                if (!bus.filterEnable[i]) begin
                    mFilt[i]       = syncOut[i];
                    mismatchRun[i] = 0;
                end else if (tick) begin
                    if (syncOut[i] == mFilt[i]) begin
                        mismatchRun[i] = 0;
                    end else begin
                        mismatchRun[i]++;
                        if (mismatchRun[i] > int'(bus.debounceCount)) begin
                            mFilt[i]       = syncOut[i];
                            mismatchRun[i] = 0;
                        end
                    end
                end
            end
            e.filtered = mFilt;
            e.rising   = (mFilt & ~prevFilt) & edgeMask;
            e.falling  = (~mFilt & prevFilt) & edgeMask;
        end
        expQ.push_back(e);
    endtask

    // One clock: wait for the edge, step the model, leave time for outputs to settle.
    task automatic cycle();
        @(posedge clk);
        #1;
        modelStep();
    endtask

    task automatic doReset();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("rstFiltered", 32'(bus.gpio_filtered), 32'h0);
            check("rstRising", 32'(bus.gpio_risingEdge), 32'h0);
            check("rstFalling", 32'(bus.gpio_fallingEdge), 32'h0);
        end
        rst = 1'b0;
    endtask

    // Scoreboard monitor: compares every edge's outputs against the model.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            monExp = expQ.pop_front();
            check("sbFiltered", 32'(bus.gpio_filtered), 32'(monExp.filtered));
            check("sbRising", 32'(bus.gpio_risingEdge), 32'(monExp.rising));
            check("sbFalling", 32'(bus.gpio_fallingEdge), 32'(monExp.falling));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] pad;
        bus.pad_input     = 16'hFFFF;
        bus.filterEnable  = 16'h0000;
        bus.samplePeriod  = 16'd0;
        bus.debounceCount = 4'd0;
        padDelay          = '{16'h0000, 16'h0000};
        cyclesSinceTick   = 0;
        mFilt             = '0;

        // Reset with all pads high: output appears 3 edges after release.
        doReset();
        cycle(); check("relE1Filtered", 32'(bus.gpio_filtered), 32'h0);
        cycle(); check("relE2Filtered", 32'(bus.gpio_filtered), 32'h0);
        cycle(); check("relE3Filtered", 32'(bus.gpio_filtered), 32'hFFFF);
                 check("relE3Rising", 32'(bus.gpio_risingEdge), 32'(16'hFFFF & edgeMask));
        cycle(); check("relE4Rising", 32'(bus.gpio_risingEdge), 32'h0);

        // Bypass latency on pin 3.
        bus.pad_input = 16'h0000;
        repeat (5) cycle();
        bus.pad_input = 16'h0008;
        cycle(); check("bypN", 32'(bus.gpio_filtered), 32'h0);
        cycle(); check("bypN1", 32'(bus.gpio_filtered), 32'h0);
        cycle(); check("bypN2", 32'(bus.gpio_filtered), 32'h0008);
                 check("bypN2Rising", 32'(bus.gpio_risingEdge), 32'(16'h0008 & edgeMask));
        cycle(); check("bypN3Rising", 32'(bus.gpio_risingEdge), 32'h0);
                 check("bypN3Filtered", 32'(bus.gpio_filtered), 32'h0008);

        // Debounce: period 5 cycles, 3 mismatching ticks; pin 0 steady high,
        // pin 1 a 6-cycle pulse, pin 2 high 2 ticks / low 1 tick / high 3 ticks.
        bus.filterEnable  = 16'hFFFF;
        bus.samplePeriod  = 16'd4;
        bus.debounceCount = 4'd2;
        bus.pad_input     = 16'h0000;
        doReset();
        for (int k = 1; k <= 35; k++) begin
            pad = 16'h0001;
            pad[1] = (k <= 6);
            pad[2] = (k <= 10) || (k >= 16);
            bus.pad_input = pad;
            cycle();
            if (k == 14) check("dbPin0Before", 32'(bus.gpio_filtered[0]), 32'h0);
            if (k == 15) check("dbPin0After", 32'(bus.gpio_filtered[0]), 32'h1);
            if (k == 29) check("bouncePin2Before", 32'(bus.gpio_filtered[2]), 32'h0);
            if (k == 30) check("bouncePin2After", 32'(bus.gpio_filtered[2]), 32'h1);
            if (k == 35) check("glitchPin1", 32'(bus.gpio_filtered[1]), 32'h0);
        end

        // samplePeriod 0 with debounceCount 0: same latency as bypass.
        bus.samplePeriod  = 16'd0;
        bus.debounceCount = 4'd0;
        bus.pad_input     = 16'h0000;
        doReset();
        repeat (3) cycle();
        bus.pad_input = 16'h0020;
        cycle(); check("sp0N", 32'(bus.gpio_filtered), 32'h0);
        cycle(); check("sp0N1", 32'(bus.gpio_filtered), 32'h0);
        cycle(); check("sp0N2", 32'(bus.gpio_filtered), 32'h0020);

        // Lower samplePeriod from 1000 to 2 while the prescaler sits at 500.
        bus.samplePeriod = 16'd1000;
        bus.pad_input    = 16'h0000;
        doReset();
        bus.pad_input = 16'h0040;
        repeat (500) cycle();
        check("spJumpBefore", 32'(bus.gpio_filtered), 32'h0);
        bus.samplePeriod = 16'd2;
        cycle();
        check("spJumpAfter", 32'(bus.gpio_filtered), 32'h0040);

        // Randomized phase: sparse pad toggles, occasional config changes and resets.
        bus.samplePeriod  = 16'(($urandom_range(0, 6)));
        bus.debounceCount = 4'(($urandom_range(0, 3)));
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) bus.filterEnable = 16'($urandom);
            if ($urandom_range(0, 149) == 0) bus.samplePeriod = 16'($urandom_range(0, 7));
            if ($urandom_range(0, 149) == 0) bus.debounceCount = 4'($urandom_range(0, 3));
            bus.pad_input = bus.pad_input ^ 16'($urandom & $urandom & $urandom & $urandom);
            cycle();
        end
        rst = 1'b0;
        repeat (3) cycle();

        for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clk);
        #1;
        check("queueDrain", 32'(expQ.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
